// File: rtl/funct_generator_pipe.sv
// Pipelined signed MUL/ADD/SUB/MAC generator with valid/ready handshake.
// LAT register stages (the last one drives the outputs); a stall freezes the whole pipe.
module funct_generator_pipe #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned LAT        = 2,
    parameter int unsigned SAT        = 0
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      valid_i,
    output logic                      ready_o,
    input  logic [1:0]                op_i,
    input  logic [DATA_WIDTH-1:0]     a_i,
    input  logic [DATA_WIDTH-1:0]     b_i,
    input  logic                      clr_acc_i,
    output logic [2*DATA_WIDTH-1:0]   data_o,
    output logic                      valid_o,
    input  logic                      ready_i,
    output logic                      ovf_o
);

    localparam int unsigned RW = 2 * DATA_WIDTH;

    localparam logic [1:0] OP_MUL = 2'b00;
    localparam logic [1:0] OP_ADD = 2'b01;
    localparam logic [1:0] OP_SUB = 2'b10;
    localparam logic [1:0] OP_MAC = 2'b11;

    localparam logic [RW-1:0] SAT_MAX = {1'b0, {(RW-1){1'b1}}};
    localparam logic [RW-1:0] SAT_MIN = {1'b1, {(RW-1){1'b0}}};

    logic                 stall;
    logic                 accept;
    logic                 is_mac;
    logic                 mac_ovf;
    logic signed [RW-1:0] a_ext;
    logic signed [RW-1:0] b_ext;
    logic signed [RW-1:0] prod;
    logic signed [RW-1:0] acc;
    logic signed [RW-1:0] acc_base;
    logic signed [RW-1:0] mac_res;
    logic signed [RW-1:0] result;
    logic signed [RW:0]   mac_wide;

    logic [LAT-1:0]         stage_valid;
    logic [LAT-1:0][RW-1:0] stage_data;
    logic [LAT-1:0]         valid_next;
    logic [LAT-1:0][RW-1:0] data_next;

    assign stall   = valid_o & ~ready_i;
    assign ready_o = ~stall;
    assign accept  = valid_i & ready_o;
    assign is_mac  = (op_i == OP_MAC);

    // Operation datapath, evaluated in the acceptance cycle.
    always_comb begin
        a_ext    = RW'($signed(a_i));
        b_ext    = RW'($signed(b_i));
        prod     = a_ext * b_ext;
        acc_base = clr_acc_i ? '0 : acc;
        mac_wide = (RW+1)'(acc_base) + (RW+1)'(prod);
        mac_ovf  = mac_wide[RW] ^ mac_wide[RW-1];
        mac_res  = mac_wide[RW-1:0];
        if ((SAT != 0) && mac_ovf) begin
            mac_res = mac_wide[RW] ? SAT_MIN : SAT_MAX;
        end
        case (op_i)
            OP_MUL:  result = prod;
            OP_ADD:  result = a_ext + b_ext;
            OP_SUB:  result = a_ext - b_ext;
            default: result = mac_res;
        endcase
    end

    // Stage inputs; data only moves with a valid beat so the output holds between results.
    for (genvar g = 0; g < int'(LAT); g++) begin : g_stage
        if (g == 0) begin : g_head
            assign valid_next[g] = accept;
            assign data_next[g]  = accept ? result : stage_data[g];
        end else begin : g_body
            assign valid_next[g] = stage_valid[g-1];
            assign data_next[g]  = stage_valid[g-1] ? stage_data[g-1] : stage_data[g];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stage_valid <= '0;
            stage_data  <= '0;
        end else if (!stall) begin
            stage_valid <= valid_next;
            stage_data  <= data_next;
        end
    end

    assign valid_o = stage_valid[LAT-1];
    assign data_o  = stage_data[LAT-1];

    // Accumulator: clear applies even while stalled; non-MAC beats leave it alone.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc <= '0;
        end else if (accept && is_mac) begin
            acc <= mac_res;
        end else if (clr_acc_i) begin
            acc <= '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ovf_o <= 1'b0;
        end else if (clr_acc_i) begin
            ovf_o <= 1'b0;
        end else if ((SAT != 0) && accept && is_mac && mac_ovf) begin
            ovf_o <= 1'b1;
        end
    end

endmodule
